// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the iterative radix-2 signed divider.
//   - div_state_e : controller states (IDLE, CALC, DONE)
//   - dbz_quot()  : quotient reported for a zero divisor (all ones, i.e. -1)
//   - ovf_quot()  : quotient reported for the single overflowing case
//                   (-2^(w-1) / -1), which is -2^(w-1) itself
//   - ovf_rem()   : remainder reported for the overflowing case
// The constant functions return 32-bit values. The caller truncates them to
// its own operand width, so one definition serves every legal width (4..32).
// -----------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // All ones in the low w bits.
  function automatic logic [31:0] dbz_quot(input int unsigned w);
    return 32'hFFFF_FFFF >> (32'd32 - w);
  endfunction

  // Most negative w-bit two's-complement value.
  function automatic logic [31:0] ovf_quot(input int unsigned w);
    return 32'h0000_0001 << (w - 32'd1);
  endfunction

  // The overflow case always divides exactly.
  function automatic logic [31:0] ovf_rem();
    return 32'h0000_0000;
  endfunction

endpackage

// File: rtl/divider_radix2_iter_restoring_step.sv
// -----------------------------------------------------------------------------
// divider_RestoringStep
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_in  [width:0] : partial remainder entering the step
//   div_mag [width:0] : divisor magnitude
//   bit_in            : next dividend bit, MSB first
//   rem_out [width:0] : partial remainder after the step
//   q_bit             : quotient bit produced by the step
// -----------------------------------------------------------------------------
module divider_RestoringStep #(
  parameter int width = 8
) (
  input  logic [width:0] rem_in,
  input  logic [width:0] div_mag,
  input  logic           bit_in,
  output logic [width:0] rem_out,
  output logic           q_bit
);

  logic [width+1:0] trial_s;
  logic [width+1:0] diff_s;

  // Shift in the next dividend bit, then trial-subtract the divisor.
  // For a non-zero divisor rem_in < div_mag <= 2^(width-1), so trial_s stays
  // below 2^(width+1) and the top bit of the difference is a clean borrow.
  always_comb begin
    trial_s = {rem_in, bit_in};
    diff_s  = trial_s - {1'b0, div_mag};
    q_bit   = ~diff_s[width+1];
    if (q_bit) begin
      rem_out = diff_s[width:0];
    end else begin
      rem_out = trial_s[width:0];
    end
  end

endmodule

// File: rtl/divider_radix2_iter.sv
// -----------------------------------------------------------------------------
// divider_radix2_iter
// Iterative signed divider. It computes one restoring radix-2 step per clock
// on operand magnitudes, then applies the sign correction when it writes the
// output registers. Results truncate toward zero, and the remainder takes the
// sign of the dividend.
//
// Parameters:
//   width     : operand/result width in bits (4..32)
//   cnt_width : iteration counter width
// Ports:
//   clk          : clock; all state changes on the rising edge
//   reset        : asynchronous active-low reset
//   in_val       : request valid
//   in_rdy       : divider idle and able to accept a request
//   in_dividend  : signed dividend
//   in_divisor   : signed divisor
//   out_val      : result valid; stays high until out_rdy is seen
//   out_rdy      : consumer accepts the result
//   out_quot     : signed quotient
//   out_rem      : signed remainder
//   out_dbz      : divide-by-zero flag, valid with out_val
//                  (present only when DIVIDER_RADIX2_ITER_DBZ_FLAG_EN is defined)
//
// Timing: the accepting cycle is followed by width CALC cycles and then DONE.
// out_val is therefore high width+1 cycles after the accepting cycle.
// Back-to-back requests complete once every width+2 cycles.
// -----------------------------------------------------------------------------
module divider_radix2_iter
  import divider_pkg::*;
#(
  parameter int width     = 8,
  parameter int cnt_width = $clog2(width + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [width-1:0] in_dividend,
  input  logic [width-1:0] in_divisor,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [width-1:0] out_quot,
  output logic [width-1:0] out_rem
`ifdef DIVIDER_RADIX2_ITER_DBZ_FLAG_EN
  ,
  output logic             out_dbz
`endif
);

  localparam logic [width-1:0]     dbz_q_c    = width'(dbz_quot(width));
  localparam logic [width-1:0]     ovf_q_c    = width'(ovf_quot(width));
  localparam logic [width-1:0]     ovf_r_c    = width'(ovf_rem());
  localparam logic [cnt_width-1:0] cnt_load_c = cnt_width'(width);
  localparam logic [cnt_width-1:0] cnt_one_c  = {{(cnt_width-1){1'b0}}, 1'b1};
  localparam logic [width:0]       one_ext_c  = {{width{1'b0}}, 1'b1};

  div_state_e state_r;
  div_state_e state_nxt_s;

  logic [cnt_width-1:0] cnt_r;
  logic                 rdy_r;
  logic                 val_r;

  // Dividend bits leave quo_r at the MSB while quotient bits enter at the
  // LSB. After width steps quo_r holds the quotient magnitude.
  logic [width-1:0] quo_r;
  logic [width:0]   prem_r;
  logic [width:0]   div_mag_r;
  logic [width-1:0] dvd_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dbz_r;
  logic             ovf_r;
  logic [width-1:0] quot_r;
  logic [width-1:0] rem_r;

  logic             accept_s;
  logic             step_s;
  logic             last_s;
  logic             release_s;
  logic [width-1:0] dvd_mag_s;
  logic [width:0]   dvr_ext_s;
  logic [width:0]   dvr_mag_s;
  logic             dbz_in_s;
  logic             ovf_in_s;
  logic [width:0]   prem_nxt_s;
  logic             q_bit_s;
  logic [width-1:0] q_mag_s;
  logic [width-1:0] r_mag_s;
  logic [width-1:0] quot_fin_s;
  logic [width-1:0] rem_fin_s;

  // Operand magnitudes and special-case detection on the request inputs.
  // The dividend magnitude fits in width unsigned bits even for -2^(width-1).
  // The divisor magnitude is kept at width+1 bits to match the step datapath.
  always_comb begin
    if (in_dividend[width-1]) begin
      dvd_mag_s = ~in_dividend + {{(width-1){1'b0}}, 1'b1};
    end else begin
      dvd_mag_s = in_dividend;
    end
    dvr_ext_s = {in_divisor[width-1], in_divisor};
    if (dvr_ext_s[width]) begin
      dvr_mag_s = ~dvr_ext_s + one_ext_c;
    end else begin
      dvr_mag_s = dvr_ext_s;
    end
    dbz_in_s = (in_divisor == {width{1'b0}});
    ovf_in_s = (in_dividend == ovf_q_c) && (in_divisor == dbz_q_c);
  end

  divider_RestoringStep #(
    .width (width)
  ) u_step (
    .rem_in  (prem_r),
    .div_mag (div_mag_r),
    .bit_in  (quo_r[width-1]),
    .rem_out (prem_nxt_s),
    .q_bit   (q_bit_s)
  );

  // Sign correction and special-case substitution for the final step.
  always_comb begin
    q_mag_s = {quo_r[width-2:0], q_bit_s};
    r_mag_s = prem_nxt_s[width-1:0];
    if (dbz_r) begin
      quot_fin_s = dbz_q_c;
      rem_fin_s  = dvd_r;
    end else if (ovf_r) begin
      quot_fin_s = ovf_q_c;
      rem_fin_s  = ovf_r_c;
    end else begin
      if (q_neg_r) begin
        quot_fin_s = ~q_mag_s + {{(width-1){1'b0}}, 1'b1};
      end else begin
        quot_fin_s = q_mag_s;
      end
      if (r_neg_r) begin
        rem_fin_s = ~r_mag_s + {{(width-1){1'b0}}, 1'b1};
      end else begin
        rem_fin_s = r_mag_s;
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Controller next-state and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_val && rdy_r) begin
          accept_s    = 1'b1;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (cnt_r == cnt_one_c) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (out_rdy) begin
          release_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Handshake flags registered from the next state. rdy_r stays low for the
  // first cycle after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_r <= 1'b0;
      val_r <= 1'b0;
    end else begin
      rdy_r <= (state_nxt_s == IDLE);
      val_r <= (state_nxt_s == DONE);
    end
  end

  // Iteration counter: loaded on accept, and reaches 0 on the final step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {cnt_width{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_load_c;
    end else if (step_s) begin
      cnt_r <= cnt_r - cnt_one_c;
    end
  end

  // Operand, sign and iteration datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_r     <= {width{1'b0}};
      prem_r    <= {(width+1){1'b0}};
      div_mag_r <= {(width+1){1'b0}};
      dvd_r     <= {width{1'b0}};
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      dbz_r     <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (accept_s) begin
      quo_r     <= dvd_mag_s;
      prem_r    <= {(width+1){1'b0}};
      div_mag_r <= dvr_mag_s;
      dvd_r     <= in_dividend;
      q_neg_r   <= in_dividend[width-1] ^ in_divisor[width-1];
      r_neg_r   <= in_dividend[width-1];
      dbz_r     <= dbz_in_s;
      ovf_r     <= ovf_in_s;
    end else if (step_s) begin
      quo_r  <= {quo_r[width-2:0], q_bit_s};
      prem_r <= prem_nxt_s;
    end
  end

  // Result registers: written once, on the final step, and held through DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quot_r <= {width{1'b0}};
      rem_r  <= {width{1'b0}};
    end else if (last_s) begin
      quot_r <= quot_fin_s;
      rem_r  <= rem_fin_s;
    end
  end

`ifdef DIVIDER_RADIX2_ITER_DBZ_FLAG_EN
  logic dbz_out_r;

  // Divide-by-zero flag: high only while the result it belongs to is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbz_out_r <= 1'b0;
    end else if (last_s) begin
      dbz_out_r <= dbz_r;
    end else if (release_s) begin
      dbz_out_r <= 1'b0;
    end
  end

  assign out_dbz = dbz_out_r;
`endif

  assign in_rdy   = rdy_r;
  assign out_val  = val_r;
  assign out_quot = quot_r;
  assign out_rem  = rem_r;

endmodule

// File: tb/tb_divider_radix2_iter.sv
module tb_divider_radix2_iter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_val;
  logic         in_rdy;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         out_val;
  logic         out_rdy;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;
`ifdef DIVIDER_RADIX2_ITER_DBZ_FLAG_EN
  logic         out_dbz;
`endif

  divider_radix2_iter #(.width(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_quot    (out_quot),
    .out_rem     (out_rem)
`ifdef DIVIDER_RADIX2_ITER_DBZ_FLAG_EN
    ,
    .out_dbz     (out_dbz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   acc_gap = 0;
  int   acc_count = 0;
  bit   seen = 1'b0;
  bit   bp_en = 1'b0;

  // Directed vectors with hand-computed results.
  logic [W-1:0] ta[12] = '{8'd100, 8'h9C, 8'd100, 8'h80, 8'd37, 8'h80,
                           8'd9,   8'hF9, 8'h7F,  8'h80, 8'd5,  8'hFF};
  logic [W-1:0] tb[12] = '{8'd7,   8'd7,  8'hF9,  8'hFF, 8'd0,  8'd1,
                           8'd3,   8'd2,  8'h80,  8'h80, 8'd9,  8'hFF};
  logic [W-1:0] tq[12] = '{8'd14,  8'hF2, 8'hF2,  8'h80, 8'hFF, 8'h80,
                           8'd3,   8'hFD, 8'd0,   8'd1,  8'd0,  8'd1};
  logic [W-1:0] tr[12] = '{8'd2,   8'hFE, 8'd2,   8'd0,  8'd37, 8'd0,
                           8'd0,   8'hFF, 8'h7F,  8'd0,  8'd5,  8'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Golden model: signed division with truncation toward zero, plus the
  // divide-by-zero and overflow rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai;
    int   bi;
    ai = $signed(a);
    bi = $signed(b);
    e.dbz = 1'b0;
    if (bi == 0) begin
      e.q   = {W{1'b1}};
      e.r   = a;
      e.dbz = 1'b1;
    end else if (ai == -(2 ** (W - 1)) && bi == -1) begin
      e.q = W'(-(2 ** (W - 1)));
      e.r = {W{1'b0}};
    end else begin
      e.q = W'(ai / bi);
      e.r = W'(ai % bi);
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Random output backpressure, enabled only for the sweep.
  always @(posedge clk) begin
    #1;
    if (bp_en) out_rdy = 1'($urandom_range(0, 1));
  end

  // Compare process: record each acceptance, and check every cycle in which a
  // result is presented.
  always @(negedge clk) begin
    if (reset) begin
      if (in_val && in_rdy) begin
        exp_q.push_back(model(in_dividend, in_divisor));
        acc_gap = cyc - acc_cyc;
        acc_cyc = cyc;
        acc_count++;
      end
      if (out_val) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_val", 32'(out_val), 32'd0);
        end else begin
          check("quot", 32'(out_quot), 32'(exp_q[0].q));
          check("rem", 32'(out_rem), 32'(exp_q[0].r));
`ifdef DIVIDER_RADIX2_ITER_DBZ_FLAG_EN
          check("dbz", 32'(out_dbz), 32'(exp_q[0].dbz));
`endif
          check("in_rdy_in_done", 32'(in_rdy), 32'd0);
          if (!seen) begin
            check("latency", 32'(cyc - acc_cyc), 32'(W + 1));
            seen = 1'b1;
          end
          if (out_rdy) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!in_rdy && t < 300) begin
      tick();
      t++;
    end
    if (!in_rdy) check("rdy_timeout", 32'(in_rdy), 32'd1);
    in_dividend = a;
    in_divisor  = b;
    in_val      = 1'b1;
    tick();
    in_val      = 1'b0;
    in_dividend = W'($urandom);
    in_divisor  = W'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n0;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset       = 1'b0;
    in_val      = 1'b0;
    out_rdy     = 1'b1;
    in_dividend = {W{1'b0}};
    in_divisor  = {W{1'b0}};

    // Reset values take effect before any clock edge.
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_quot", 32'(out_quot), 32'd0);
    check("rst_rem", 32'(out_rem), 32'd0);
    repeat (3) tick();
    check("rst_in_rdy_clocked", 32'(in_rdy), 32'd0);
    reset = 1'b1;
    check("rdy_before_edge", 32'(in_rdy), 32'd0);
    tick();
    check("rdy_after_edge", 32'(in_rdy), 32'd1);

    // Pin the model to the hand-computed table.
    for (int i = 0; i < 12; i++) begin
      e = model(ta[i], tb[i]);
      check("model_q", 32'(e.q), 32'(tq[i]));
      check("model_r", 32'(e.r), 32'(tr[i]));
    end
    e = model(8'd37, 8'd0);
    check("model_dbz", 32'(e.dbz), 32'd1);

    // Directed vectors through the DUT.
    for (int i = 0; i < 12; i++) begin
      run_op(ta[i], tb[i]);
      drain();
    end

    // Back-to-back throughput with in_val held high.
    out_rdy     = 1'b1;
    n0          = acc_count;
    in_dividend = 8'd50;
    in_divisor  = 8'd5;
    in_val      = 1'b1;
    repeat (2 * (W + 2) + 1) tick();
    in_val = 1'b0;
    check("b2b_accepts", 32'(acc_count - n0), 32'd3);
    check("b2b_gap", 32'(acc_gap), 32'(W + 2));
    drain();

    // Hold in DONE with out_rdy low.
    out_rdy = 1'b0;
    run_op(8'h9C, 8'd7);
    for (int t = 0; t < 40 && !out_val; t++) tick();
    check("hold_reach_done", 32'(out_val), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_val", 32'(out_val), 32'd1);
      check("hold_quot", 32'(out_quot), 32'hF2);
      check("hold_rem", 32'(out_rem), 32'hFE);
      check("hold_in_rdy", 32'(in_rdy), 32'd0);
    end
    out_rdy = 1'b1;
    drain();

    // in_val pulses during CALC are ignored.
    n0 = acc_count;
    run_op(8'd100, 8'd7);
    tick();
    tick();
    in_dividend = 8'd1;
    in_divisor  = 8'd1;
    in_val      = 1'b1;
    tick();
    tick();
    in_val = 1'b0;
    drain();
    repeat (15) tick();
    check("calc_in_val_ignored", 32'(acc_count - n0), 32'd1);

    // Reset in CALC cycle 4 abandons the operation immediately.
    run_op(8'd100, 8'd7);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("abort_out_val", 32'(out_val), 32'd0);
    check("abort_quot", 32'(out_quot), 32'd0);
    check("abort_rem", 32'(out_rem), 32'd0);
    check("abort_in_rdy", 32'(in_rdy), 32'd0);
    exp_q.delete();
    seen = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("abort_rdy_before_edge", 32'(in_rdy), 32'd0);
    tick();
    check("abort_rdy_after_edge", 32'(in_rdy), 32'd1);
    check("abort_no_result", 32'(out_val), 32'd0);
    run_op(8'd9, 8'd3);
    drain();

    // Random sweep with random backpressure and occasional special cases.
    bp_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = {W{1'b0}};
        1: begin
          a = 8'h80;
          b = 8'hFF;
        end
        default: ;
      endcase
      run_op(a, b);
      drain();
    end
    bp_en = 1'b0;
    tick();
    out_rdy = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
